// File: rtl/i2c_tof_responder.sv
// I2C target emulating one ToF sensor: 256-byte register file preloaded by
// local logic, 16-bit register addressing, auto-incrementing reads and writes,
// and an active-low "frame pending" interrupt.
module i2c_tof_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       int_n,
    input  logic       frame_valid,
    input  logic       ld_we,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REGH, REGH_ACK, REGL, REGL_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t      state_q;
    logic        scl_s1_q, scl_s2_q, scl_prev_q;
    logic        sda_s1_q, sda_s2_q, sda_prev_q;
    logic        scl_rise_q, scl_fall_q, start_q, stop_q;
    logic [3:0]  bitcnt_q;
    logic [7:0]  shift_q;
    logic [6:0]  tx_q;
    logic [7:0]  ptr_q;
    logic        pend_int_q;
    logic        wpend_q;
    logic [7:0]  wpend_addr_q, wpend_data_q;
    logic [7:0]  mem [256];

    logic [7:0]  rd_byte;
    logic        commit_new;
    logic [7:0]  commit_byte;
    logic        latch_evt;

    assign rd_byte     = mem[ptr_q];
    // The 8th data bit is taken straight from the sampled SDA so the commit
    // happens on the same cycle the bit is shifted in.
    assign commit_byte = {shift_q[6:0], sda_prev_q};
    assign commit_new  = (state_q == WDATA) && scl_rise_q && (bitcnt_q == 4'd7);
    // A read byte is latched on the SCL fall that starts its bit 7.
    assign latch_evt   = scl_fall_q && !start_q && !stop_q &&
                         (((state_q == ADDR_ACK) && shift_q[0]) || (state_q == RDATA_ACK));
    assign int_n       = ~pend_int_q;

    // Synchronize the pins and register single-cycle bus events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda_i;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
            scl_rise_q <= scl_s2_q & ~scl_prev_q;
            scl_fall_q <= ~scl_s2_q & scl_prev_q;
            start_q    <= scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
            stop_q     <= scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
        end
    end

    // Protocol FSM: bit counting, ACK driving, read shifting, pointer updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= 4'd0;
            shift_q  <= 8'd0;
            tx_q     <= 7'd0;
            ptr_q    <= 8'd0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
        end else if (stop_q) begin
            state_q <= IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else if (start_q) begin
            state_q  <= ADDR;
            bitcnt_q <= 4'd0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state_q)
                ADDR, REGH, REGL, WDATA: begin
                    if (scl_rise_q) begin
                        shift_q  <= {shift_q[6:0], sda_prev_q};
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if ((state_q == WDATA) && (bitcnt_q == 4'd7))
                            ptr_q <= ptr_q + 8'd1;
                    end else if (scl_fall_q && (bitcnt_q == 4'd8)) begin
                        sda_oe <= 1'b1;
                        case (state_q)
                            ADDR: begin
                                if (shift_q[7:1] == DEV_ADDR) begin
                                    state_q <= ADDR_ACK;
                                    busy    <= 1'b1;
                                end else begin
                                    state_q <= IGNORE;
                                    sda_oe  <= 1'b0;
                                end
                            end
                            REGH: state_q <= REGH_ACK;
                            REGL: begin
                                state_q <= REGL_ACK;
                                ptr_q   <= shift_q;
                            end
                            default: state_q <= WDATA_ACK;
                        endcase
                    end
                end
                ADDR_ACK, REGH_ACK, REGL_ACK, WDATA_ACK: begin
                    if (scl_fall_q) begin
                        sda_oe   <= 1'b0;
                        bitcnt_q <= 4'd0;
                        case (state_q)
                            ADDR_ACK: begin
                                if (shift_q[0]) begin
                                    state_q <= RDATA;
                                    tx_q    <= rd_byte[6:0];
                                    sda_oe  <= ~rd_byte[7];
                                end else begin
                                    state_q <= REGH;
                                end
                            end
                            REGH_ACK: state_q <= REGL;
                            default:  state_q <= WDATA;
                        endcase
                    end
                end
                RDATA: begin
                    if (scl_rise_q) begin
                        bitcnt_q <= bitcnt_q + 4'd1;
                    end else if (scl_fall_q) begin
                        if (bitcnt_q == 4'd8) begin
                            state_q <= RDATA_ACK;
                            sda_oe  <= 1'b0;
                        end else begin
                            sda_oe <= ~tx_q[6];
                            tx_q   <= {tx_q[5:0], 1'b0};
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise_q) begin
                        if (sda_prev_q)
                            state_q <= IGNORE;
                        else
                            ptr_q <= ptr_q + 8'd1;
                    end else if (scl_fall_q) begin
                        state_q  <= RDATA;
                        bitcnt_q <= 4'd0;
                        tx_q     <= rd_byte[6:0];
                        sda_oe   <= ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame-pending flag; a new frame wins over a simultaneous read of 0x00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pend_int_q <= 1'b0;
        else if (frame_valid)
            pend_int_q <= 1'b1;
        else if (latch_evt && (ptr_q == 8'd0))
            pend_int_q <= 1'b0;
    end

    // Single write port: local loads first, I2C commits deferred until free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
            wpend_q      <= 1'b0;
            wpend_addr_q <= 8'd0;
            wpend_data_q <= 8'd0;
            wr_strobe    <= 1'b0;
            wr_addr      <= 8'd0;
            wr_data      <= 8'd0;
        end else begin
            wr_strobe <= 1'b0;
            if (ld_we) begin
                mem[ld_addr] <= ld_data;
                if (commit_new) begin
                    wpend_q      <= 1'b1;
                    wpend_addr_q <= ptr_q;
                    wpend_data_q <= commit_byte;
                end
            end else if (wpend_q) begin
                mem[wpend_addr_q] <= wpend_data_q;
                wpend_q   <= 1'b0;
                wr_strobe <= 1'b1;
                wr_addr   <= wpend_addr_q;
                wr_data   <= wpend_data_q;
            end else if (commit_new) begin
                mem[ptr_q] <= commit_byte;
                wr_strobe  <= 1'b1;
                wr_addr    <= ptr_q;
                wr_data    <= commit_byte;
            end
        end
    end

endmodule

// File: doc/i2c_tof_responder.md
# i2c_tof_responder

- Synthesizable I2C target that emulates one ToF sensor at its bus address, for hardware-in-the-loop tests of the ToF I2C master modules.
- Holds a 256-byte register file that local logic preloads with a measurement frame, then signals "data ready" on an active-low interrupt.
- Answers the master's 16-bit-register-addressed writes and auto-incrementing reads.
- Sits on one lane of the ToF_SCL/ToF_SDA/ToF_INT buses, in place of a physical sensor.

## Interface

Parameters:
- DEV_ADDR, 7'h29, 7-bit I2C target address.

Ports:
- clk  in  1  system clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high.
- scl_i  in  1  SCL pin level, asynchronous to clk.
- sda_i  in  1  SDA pin level, asynchronous to clk.
- sda_oe  out  1  1 = drive SDA low; 0 = release. SDA is never driven high.
- int_n  out  1  low while a frame is pending.
- frame_valid  in  1  1-cycle pulse; sets frame pending.
- ld_we  in  1  local write enable into the register file.
- ld_addr  in  8  local write address.
- ld_data  in  8  local write data.
- wr_strobe  out  1  1-cycle pulse when an I2C-written byte commits.
- wr_addr  out  8  address of the committed byte; holds its value between strobes.
- wr_data  out  8  data of the committed byte; holds its value between strobes.
- busy  out  1  high from the address ACK of this target until STOP or the next START.

## Operation

**Input conditioning**
- scl_i and sda_i each pass through a 2-FF synchronizer, then a 1-FF edge detector.
- START = SDA falling while SCL high.
- STOP = SDA rising while SCL high.
- Data bits are sampled on SCL rising.
- sda_oe changes only in the cycle after SCL falling is detected.

**FSM states:** IDLE, ADDR, ADDR_ACK, REGH, REGH_ACK, REGL, REGL_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.

**Addressing and register pointer**
- START from any state: go to ADDR and clear the bit counter. The register pointer is retained, so repeated START works.
- STOP from any state: go to IDLE, release sda_oe, drop busy.
- ADDR: shift in 8 bits, MSB first.
  - If the upper 7 bits equal DEV_ADDR and R/W = 0: ADDR_ACK, then REGH.
  - If they match and R/W = 1: ADDR_ACK, then RDATA.
  - If they do not match: IGNORE (no ACK) until START or STOP.
- REGH: the received byte is discarded; ACK it.
- REGL: the received byte loads the pointer; ACK it.
- All ACKs drive SDA low for exactly the 9th SCL period.

**Master write**
- WDATA: each byte is written to regfile[pointer], wr_strobe pulses, the byte is ACKed, and the pointer is incremented.
- The pointer wraps 0xFF to 0x00.

**Master read**
- RDATA: shift out regfile[pointer] MSB first. Drive 0 bits by asserting sda_oe; release for 1 bits.
- The byte is latched at the SCL falling edge that starts bit 7.
- RDATA_ACK: release SDA and sample the master's ACK.
  - ACK (0): increment the pointer (with wrap) and continue in RDATA.
  - NACK: go to IGNORE.

**Interrupt pending flag**
- Set by frame_valid.
- Cleared when a read byte is latched from address 0x00.
- If set and clear coincide, set wins.
- int_n = ~pending.

**Register file write collision**
- The register file has one write port, and ld_we has priority.
- An I2C commit that coincides with ld_we is held in a pending register and retried each cycle until ld_we is low.
- wr_strobe pulses in the cycle the write actually occurs.
- ld_we must not stay high longer than 8 SCL periods.

## Timing

**Reset values**
- sda_oe = 0, int_n = 1, busy = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0.
- Pointer = 0, regfile all 0, FSM in IDLE, synchronizers preset to 1.
- An asserted reset mid-transfer releases SDA immediately (asynchronous).

**Latencies**
- Pin change to detected edge: 3 clk.
- SCL pin falling to sda_oe update: 4 clk.
- The 8th data bit's SCL rising (pin) to wr_strobe: 4 clk with no collision; +1 clk per cycle of ld_we collision.
- frame_valid to int_n low: 1 clk.
- Local write: ld_we with ld_addr/ld_data is visible in the register file on the next cycle.

**Clock constraint**
- clk ≥ 16× SCL frequency: 400 kHz bus needs clk ≥ 6.4 MHz.
- Below this, behaviour is undefined.

## Test plan

1. **Write with wrap:** write 0x52, regs 0x00 0xFE, data 0xA5 0x5A 0x3C -> three ACKs; regfile[FE]=A5, [FF]=5A, [00]=3C; three wr_strobe pulses with matching wr_addr/wr_data; busy high until STOP.
2. **Read with repeated START:** preload regfile[10..13]=11,22,33,44 via ld_we; write 0x52, reg 0x0010, repeated START, 0x53, read 4 bytes with NACK on the last -> SDA returns 11 22 33 44; SDA released after NACK.
3. **Address mismatch:** 0x54 write -> no ACK; sda_oe stays 0 for the whole transfer; busy stays 0.
4. **Interrupt:**
   - frame_valid -> int_n low after 1 clk.
   - Read of reg 0x0000 -> int_n high after the byte latch.
   - frame_valid in the same cycle as that latch -> int_n stays low.
5. **Collision:** hold ld_we (addr 0x20, data 0x99) across an I2C commit to 0x21 -> regfile[20]=99; regfile[21] is written the cycle after ld_we drops; wr_strobe pulses once.
6. **Reset mid-read:** assert reset while sda_oe=1 -> sda_oe 0 in the same cycle; the next START/0x53 read returns regfile[00]=0.
